// File: rtl/ksa16b_pipe_addsub_if.sv
// Operand/result handshake bundle for the pipelined Kogge-Stone adder/subtractor.
// The master drives operands and consumes results; the slave is the arithmetic block.
interface ksa16b_pipe_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/ksa16b_pipe_addsub.sv
// Two-stage pipelined WIDTH-bit adder/subtractor built on a Kogge-Stone prefix tree,
// with the prefix levels split across the two registers and valid/ready flow control.
module ksa16b_pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int SPLIT = WIDTH / 2
) (
  input logic                clk,
  input logic                rst,
  ksa16b_pipe_addsub_if.slave bus
);

  localparam int LEVELS    = $clog2(WIDTH);
  localparam int S1_LEVELS = $clog2(SPLIT);

  logic adv1;
  logic adv2;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_pbit_q, s1_pbit_d;
  logic [WIDTH-1:0] s1_grp_g_q, s1_grp_g_d;
  logic [WIDTH-1:0] s1_grp_p_q, s1_grp_p_d;
  logic             s1_cin_q, s1_cin_d;
  logic             s1_a_msb_q, s1_a_msb_d;
  logic             s1_bb_msb_q, s1_bb_msb_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] pre1_g, pre1_p;
  logic [WIDTH-1:0] pre2_g, pre2_p;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_calc;

  // Stall propagates backwards: a stage may move only if the one after it can take its bundle.
  always_comb begin
    adv2 = !s2_valid_q || bus.out_ready;
    adv1 = !s1_valid_q || adv2;
  end

  // First prefix levels; descending bit order lets each level update in place.
  always_comb begin
    bb     = bus.op ? ~bus.b : bus.b;
    pre1_g = bus.a & bb;
    pre1_p = bus.a ^ bb;
    for (int lvl = 0; lvl < S1_LEVELS; lvl++) begin
      for (int i = WIDTH - 1; i >= (1 << lvl); i--) begin
        pre1_g[i] = pre1_g[i] | (pre1_p[i] & pre1_g[i - (1 << lvl)]);
        pre1_p[i] = pre1_p[i] & pre1_p[i - (1 << lvl)];
      end
    end
  end

  always_comb begin
    pre2_g = s1_grp_g_q;
    pre2_p = s1_grp_p_q;
    for (int lvl = S1_LEVELS; lvl < LEVELS; lvl++) begin
      for (int i = WIDTH - 1; i >= (1 << lvl); i--) begin
        pre2_g[i] = pre2_g[i] | (pre2_p[i] & pre2_g[i - (1 << lvl)]);
        pre2_p[i] = pre2_p[i] & pre2_p[i - (1 << lvl)];
      end
    end
    carry    = {pre2_g | (pre2_p & {WIDTH{s1_cin_q}}), s1_cin_q};
    sum_calc = s1_pbit_q ^ carry[WIDTH-1:0];
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_pbit_d   = s1_pbit_q;
    s1_grp_g_d  = s1_grp_g_q;
    s1_grp_p_d  = s1_grp_p_q;
    s1_cin_d    = s1_cin_q;
    s1_a_msb_d  = s1_a_msb_q;
    s1_bb_msb_d = s1_bb_msb_q;
    s2_valid_d  = s2_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    if (adv1) begin
      s1_valid_d  = bus.in_valid;
      s1_pbit_d   = bus.a ^ bb;
      s1_grp_g_d  = pre1_g;
      s1_grp_p_d  = pre1_p;
      s1_cin_d    = bus.cin;
      s1_a_msb_d  = bus.a[WIDTH-1];
      s1_bb_msb_d = bb[WIDTH-1];
    end
    // Data moves on bubbles too; only valid-qualified contents matter downstream.
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      sum_d      = sum_calc;
      cout_d     = carry[WIDTH];
      ovf_d      = (s1_a_msb_q == s1_bb_msb_q) && (sum_calc[WIDTH-1] != s1_a_msb_q);
      zero_d     = ~|sum_calc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_pbit_q   <= '0;
      s1_grp_g_q  <= '0;
      s1_grp_p_q  <= '0;
      s1_cin_q    <= 1'b0;
      s1_a_msb_q  <= 1'b0;
      s1_bb_msb_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_pbit_q   <= s1_pbit_d;
      s1_grp_g_q  <= s1_grp_g_d;
      s1_grp_p_q  <= s1_grp_p_d;
      s1_cin_q    <= s1_cin_d;
      s1_a_msb_q  <= s1_a_msb_d;
      s1_bb_msb_q <= s1_bb_msb_d;
      s2_valid_q  <= s2_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = s2_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_ksa16b_pipe_addsub.sv
// Bench for ksa16b_pipe_addsub: directed vectors, back-pressure, random streaming and
// mid-stream reset, with results scored in order against an arithmetic reference model.
module tb_ksa16b_pipe_addsub;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   check_count = 0;
  int   error_count = 0;
  logic stall_phase = 1'b0;
  exp_t exp_q[$];

  ksa16b_pipe_addsub_if #(.WIDTH(16)) bus ();

  ksa16b_pipe_addsub #(.WIDTH(16), .SPLIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic exp_t mkExp(input logic [15:0] s, input logic c, input logic o, input logic z);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    e.zero = z;
    return e;
  endfunction

  // Reference: unsigned total for sum/carry, signed total range for overflow.
  function automatic exp_t refModel(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic op);
    exp_t e;
    int ub, total, sa, sb, stotal;
    ub     = op ? (65535 - int'(b)) : int'(b);
    total  = int'(a) + ub + int'(cin);
    sa     = (int'(a) >= 32768) ? int'(a) - 65536 : int'(a);
    sb     = (ub >= 32768) ? ub - 65536 : ub;
    stotal = sa + sb + int'(cin);
    e.sum  = 16'(total % 65536);
    e.cout = (total >= 65536);
    e.ovf  = (stotal > 32767) || (stotal < -32768);
    e.zero = ((total % 65536) == 0);
    return e;
  endfunction

  task automatic applyStimulus(input logic [15:0] a_in, input logic [15:0] b_in,
                               input logic cin_in, input logic op_in, input exp_t e);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = a_in;
    bus.b        = b_in;
    bus.cin      = cin_in;
    bus.op       = op_in;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic goIdle();
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    checkOutput("drain_pending", exp_q.size(), 0);
  endtask

  // Scoreboard: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("sum", bus.sum, e.sum);
        checkOutput("cout", bus.cout, e.cout);
        checkOutput("ovf", bus.ovf, e.ovf);
        checkOutput("zero", bus.zero, e.zero);
      end
    end
  end

  always @(posedge clk) begin
    if (stall_phase) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int gaps;
    logic [15:0] ra, rb;
    logic rc, ro;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_sum", bus.sum, 0);
    checkOutput("reset_cout", bus.cout, 0);
    checkOutput("reset_ovf", bus.ovf, 0);
    checkOutput("reset_zero", bus.zero, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_reset", bus.in_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] directed add/subtract vectors");
    applyStimulus(16'h1234, 16'h5678, 1'b0, 1'b0, mkExp(16'h68AC, 1'b0, 1'b0, 1'b0));
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, mkExp(16'h0000, 1'b1, 1'b0, 1'b1));
    applyStimulus(16'h68AC, 16'h5678, 1'b1, 1'b1, mkExp(16'h1234, 1'b1, 1'b0, 1'b0));
    applyStimulus(16'h0000, 16'h0001, 1'b1, 1'b1, mkExp(16'hFFFF, 1'b0, 1'b0, 1'b0));
    applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b1, mkExp(16'h7FFF, 1'b1, 1'b1, 1'b0));
    applyStimulus(16'h7FFF, 16'h0001, 1'b1, 1'b0, mkExp(16'h8001, 1'b0, 1'b1, 1'b0));
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, mkExp(16'h0000, 1'b1, 1'b1, 1'b1));
    applyStimulus(16'h0005, 16'h0003, 1'b0, 1'b1, mkExp(16'h0001, 1'b1, 1'b0, 1'b0));
    goIdle();
    waitDrain();
    checkOutput("idle_out_valid", bus.out_valid, 0);

    $display("[TB] back-pressure");
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 2; i++)
      applyStimulus(16'(i), 16'(i), 1'b0, 1'b0, mkExp(16'(2 * i), 1'b0, 1'b0, 1'b0));
    bus.a = 16'd3;
    bus.b = 16'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", bus.in_ready, 0);
      checkOutput("stall_out_valid", bus.out_valid, 1);
      checkOutput("stall_sum_hold", bus.sum, 16'h0002);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 3; i <= 4; i++)
      applyStimulus(16'(i), 16'(i), 1'b0, 1'b0, mkExp(16'(2 * i), 1'b0, 1'b0, 1'b0));
    goIdle();
    waitDrain();

    $display("[TB] full-rate random stream");
    gaps = 0;
    for (int k = 0; k < 100; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc, ro, refModel(ra, rb, rc, ro));
      if (k >= 1 && !bus.out_valid) gaps++;
    end
    goIdle();
    waitDrain();
    checkOutput("stream_gaps", gaps, 0);

    $display("[TB] random back-pressure");
    stall_phase = 1'b1;
    for (int k = 0; k < 60; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc, ro, refModel(ra, rb, rc, ro));
    end
    goIdle();
    stall_phase = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    waitDrain();

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, mkExp(16'h3333, 1'b0, 1'b0, 1'b0));
    applyStimulus(16'h0100, 16'h0001, 1'b0, 1'b1, mkExp(16'h00FE, 1'b1, 1'b0, 1'b0));
    checkOutput("pre_reset_out_valid", bus.out_valid, 1);
    #1;
    rst = 1'b1;
    goIdle();
    exp_q.delete();
    #1;
    checkOutput("async_out_valid", bus.out_valid, 0);
    checkOutput("async_sum", bus.sum, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(16'h0001, 16'h0001, 1'b1, 1'b0, mkExp(16'h0003, 1'b0, 1'b0, 1'b0));
    goIdle();
    waitDrain();
    checkOutput("final_out_valid", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/ksa16b_pipe_addsub.md
Name: ksa16b_pipe_addsub

Overview:
- 16-bit two-stage pipelined adder/subtractor, Kogge-Stone prefix carry network, valid/ready handshake on input and output.
- Covers the subtract direction the combinational adders lack: `a - b` is computed as `a + ~b + cin`.
- Also gives the team's combinational adders a registered, back-pressure-aware counterpart for use inside datapaths.

Parameters:
- WIDTH, 16, operand/result width; must be even; prefix tree depth is clog2(WIDTH).
- SPLIT, WIDTH/2, prefix levels completed in stage 1 (clog2(SPLIT)); the remaining levels complete in stage 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept bundle this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / no-borrow-in (sub; 1 = plain a-b)
- op  input  1  0 = add a+b+cin, 1 = subtract a+~b+cin
- out_valid  output  1  result bundle valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (sub: 1 = no borrow)
- ovf  output  1  signed overflow
- zero  output  1  sum == 0

Behaviour:
- Reset (async, immediate): s1_valid=0, s2_valid=0, out_valid=0, sum=0, cout=0, ovf=0, zero=0. in_ready=1 one combinational evaluation after reset release.
- Reset mid-operation: all in-flight bundles are discarded, with no partial output. The first bundle accepted after reset release is the first result produced.
- Operand prep: bb = op ? ~b : b. Bitwise g = a&bb, p = a^bb; carry into bit 0 = cin.
- Stage 1 register captures: p, cin, the a/bb MSBs, and (G,P) after clog2(SPLIT) prefix levels.
- Stage 2 register:
  - Completes the remaining prefix levels.
  - sum[i] = p[i] ^ c[i], where c[0]=cin and c[i]=G[i-1:0] | P[i-1:0]&cin.
  - cout = c[WIDTH].
  - ovf = (aMSB == bbMSB) && (sum MSB != aMSB).
  - zero = ~|sum.
- sum/cout/ovf/zero are registered outputs. They hold their value while out_valid=1 && out_ready=0.
- Handshake:
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1 (combinational, no loop through in_valid).
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
- Stage updates:
  - On adv1: s1 loads the input bundle; s1_valid <= in_valid.
  - On adv2: s2 loads s1; s2_valid <= s1_valid.
  - Stages with adv low hold contents and valid.
- Latency: a bundle accepted at edge N is in s1 after N and at the outputs after N+1, so out_valid is visible in the cycle following edge N+1 (2 cycles). Throughput is 1 bundle/cycle with out_ready held high.
- Back-pressure: with out_ready=0, at most 2 bundles are held; in_ready drops once both stages are valid. No bundle is lost or duplicated, and order is strictly FIFO.
- Simultaneous events: when full, out transfer and in transfer occur in the same cycle if out_ready=1.
- Bubbles: an invalid s1 moving to s2 clears s2_valid. Data registers may update on bubbles; only valid-qualified data is defined.
- Wrap-around: arithmetic is modulo 2^WIDTH and the carry is reported in cout. Subtraction with cin=0 yields a-b-1.

Test Plan:
- Add, no stall: a=16'h1234, b=16'h5678, cin=0, op=0 -> 2 cycles later sum=16'h68AC, cout=0, ovf=0, zero=0. Then a=FFFF, b=0001, cin=0 -> sum=0000, cout=1, zero=1.
- Subtract: a=68AC, b=5678, cin=1, op=1 -> sum=1234, cout=1. a=0000, b=0001, cin=1, op=1 -> sum=FFFF, cout=0, ovf=0. a=8000, b=0001, cin=1, op=1 -> sum=7FFF, ovf=1.
- Signed overflow add: a=7FFF, b=0001, cin=1, op=0 -> sum=8001, cout=0, ovf=1. a=8000, b=8000, cin=0 -> sum=0000, cout=1, ovf=1, zero=1.
- Back-pressure: stream 4 bundles (add i+i, i=1..4, cin=0) with out_ready=0 for 5 cycles.
  - in_ready=0 after 2 accepts; sum=0002 is held stable.
  - Release out_ready -> 0002, 0004, 0006, 0008 in order, no gaps beyond one refill cycle, no duplicates.
- Full-rate streaming: 100 random bundles, random op/cin, out_ready=1 -> out_valid continuous after 2-cycle fill. Every result matches a±b reference including cout/ovf/zero.
- Async reset mid-stream: assert rst between edges with 2 bundles in flight -> out_valid=0 and sum=0 immediately without a clock edge. After release, the next accepted bundle (a=0001, b=0001, cin=1, op=0) -> sum=0003 is the first output.
